// File: rtl/alu_seq_if.sv
// Handshake and operand bundle between the control FSM and the multi-cycle ALU.
// The master issues ops; the slave (ALU) returns status, result and flags.
interface alu_seq_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH)
);
  logic             start;
  logic [1:0]       block_sel;
  logic [1:0]       block_func;
  logic             byte_op;
  logic             carry_in;
  logic [CNT_W-1:0] shamt;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             zero;
  logic             neg;
  logic             ovf;

  modport master (
    output start, block_sel, block_func, byte_op,
    output carry_in, shamt, src_a, src_b,
    input  busy, done, result, carry, zero, neg, ovf
  );

  modport slave (
    input  start, block_sel, block_func, byte_op,
    input  carry_in, shamt, src_a, src_b,
    output busy, done, result, carry, zero, neg, ovf
  );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle XMakina ALU: arith, logic, bit-serial shifter and move blocks.
// Operands latch on accept; result and flags register when the op completes.
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic     clk,
  input  logic     rst_n,
  alu_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] a_q, w_q, w_n;
  logic [1:0]       sel_q, func_q;
  logic             byte_q, c_q, c_n;
  logic [CNT_W-1:0] cnt_q;
  logic             done_q;
  logic [WIDTH-1:0] res_q;
  logic             c_f, z_f, n_f, v_f;
  logic             accept, is_shift;

  assign accept   = (state == IDLE) && bus.start;
  assign is_shift = (bus.block_sel == 2'd2)
                 && (bus.block_func != 2'd2)
                 && (bus.shamt != '0);

  always_comb begin
    state_n = state;
    case (state)
      IDLE:  if (accept) state_n = is_shift ? SHIFT : DONE;
      SHIFT: if (cnt_q == CNT_W'(1)) state_n = DONE;
      DONE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // One bit per cycle; byte ops keep w_q[WIDTH-1:8] untouched.
  always_comb begin
    w_n = w_q;
    c_n = c_q;
    unique case (1'b1)
      func_q == 2'd0: begin
        c_n = w_q[0];
        if (byte_q) w_n[7:0] = {w_q[7], w_q[7:1]};
        else        w_n = {w_q[WIDTH-1], w_q[WIDTH-1:1]};
      end
      func_q == 2'd1: begin
        c_n = w_q[0];
        if (byte_q) w_n[7:0] = {c_q, w_q[7:1]};
        else        w_n = {c_q, w_q[WIDTH-1:1]};
      end
      func_q == 2'd3: begin
        if (byte_q) begin
          c_n      = w_q[7];
          w_n[7:0] = {w_q[6:0], 1'b0};
        end else begin
          c_n = w_q[WIDTH-1];
          w_n = {w_q[WIDTH-2:0], 1'b0};
        end
      end
      default: ;
    endcase
  end

  logic [WIDTH-1:0] op_a, lg, mv, r;
  logic [WIDTH:0]   sum_w;
  logic [8:0]       sum_b;
  logic             ci, cr, vr, nr, zr, be, upd;

  always_comb begin
    op_a  = func_q[1] ? ~a_q : a_q;
    ci    = func_q[0] ? c_q : func_q[1];
    sum_w = {1'b0, w_q} + {1'b0, op_a} + {{WIDTH{1'b0}}, ci};
    sum_b = {1'b0, w_q[7:0]} + {1'b0, op_a[7:0]} + {8'd0, ci};
    lg    = w_q;
    mv    = a_q;
    r     = w_q;
    cr    = 1'b0;
    vr    = 1'b0;
    be    = byte_q;
    upd   = 1'b1;
    case (func_q)
      2'd0: lg = w_q ^ a_q;
      2'd1: lg = w_q & a_q;
      2'd2: lg = w_q & ~a_q;
      default: lg = w_q | a_q;
    endcase
    case (func_q)
      2'd0: mv = a_q;
      2'd1: mv = {{(WIDTH-8){1'b0}}, a_q[7:0]};
      2'd2: mv = {{(WIDTH-8){a_q[7]}}, a_q[7:0]};
      default: mv[15:0] = {a_q[7:0], a_q[15:8]};
    endcase
    case (sel_q)
      2'd0: begin
        if (byte_q) begin
          r  = {w_q[WIDTH-1:8], sum_b[7:0]};
          cr = sum_b[8];
          vr = (w_q[7] == op_a[7]) && (sum_b[7] != w_q[7]);
        end else begin
          r  = sum_w[WIDTH-1:0];
          cr = sum_w[WIDTH];
          vr = (w_q[WIDTH-1] == op_a[WIDTH-1])
            && (sum_w[WIDTH-1] != w_q[WIDTH-1]);
        end
      end
      2'd1: r = byte_q ? {w_q[WIDTH-1:8], lg[7:0]} : lg;
      2'd2: begin
        cr = c_q;
        if (func_q == 2'd2) begin
          r  = {{(WIDTH-8){w_q[7]}}, w_q[7:0]};
          be = 1'b0;
        end
      end
      default: begin
        r   = mv;
        be  = 1'b0;
        upd = 1'b0;
      end
    endcase
    nr = be ? r[7] : r[WIDTH-1];
    zr = be ? (r[7:0] == 8'd0) : (r == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      done_q <= 1'b0;
      res_q  <= '0;
      c_f    <= 1'b0;
      z_f    <= 1'b0;
      n_f    <= 1'b0;
      v_f    <= 1'b0;
      a_q    <= '0;
      w_q    <= '0;
      sel_q  <= 2'd0;
      func_q <= 2'd0;
      byte_q <= 1'b0;
      c_q    <= 1'b0;
      cnt_q  <= '0;
    end else begin
      state  <= state_n;
      done_q <= (state == DONE);
      if (accept) begin
        a_q    <= bus.src_a;
        w_q    <= bus.src_b;
        sel_q  <= bus.block_sel;
        func_q <= bus.block_func;
        byte_q <= bus.byte_op;
        c_q    <= bus.carry_in;
        cnt_q  <= bus.shamt;
      end else if (state == SHIFT) begin
        w_q   <= w_n;
        c_q   <= c_n;
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if (state == DONE) begin
        res_q <= r;
        if (upd) begin
          c_f <= cr;
          z_f <= zr;
          n_f <= nr;
          v_f <= vr;
        end
      end
    end
  end

  assign bus.busy   = (state != IDLE);
  assign bus.done   = done_q;
  assign bus.result = res_q;
  assign bus.carry  = c_f;
  assign bus.zero   = z_f;
  assign bus.neg    = n_f;
  assign bus.ovf    = v_f;
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: 16-bit instance plus a 32-bit add.
// Flags are compared as {carry, zero, neg, ovf}.
module tb_alu_seq;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(16)) u16 ();
  alu_seq_if #(.WIDTH(32)) u32 ();

  alu_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .bus(u16.slave)
  );
  alu_seq #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .bus(u32.slave)
  );

  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] fl16();
    return {u16.carry, u16.zero, u16.neg, u16.ovf};
  endfunction

  // Issue one op; inj = sample index after which start is re-pulsed.
  task automatic op16(input logic [1:0] sel, input logic [1:0] func,
                      input logic bop, input logic cin,
                      input logic [3:0] sh,
                      input logic [15:0] a, input logic [15:0] b,
                      input int inj,
                      output int lat, output int bcnt);
    @(negedge clk);
    u16.block_sel  = sel;
    u16.block_func = func;
    u16.byte_op    = bop;
    u16.carry_in   = cin;
    u16.shamt      = sh;
    u16.src_a      = a;
    u16.src_b      = b;
    u16.start      = 1'b1;
    @(posedge clk); #1;
    u16.start = 1'b0;
    lat  = -1;
    bcnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (u16.done) begin
        lat = k;
        break;
      end
      if (u16.busy) bcnt++;
      u16.start = (k == inj);
      if (k == inj) u16.src_b = 16'hFFFF;
      @(posedge clk); #1;
    end
    u16.start = 1'b0;
  endtask

  int lat, bcnt;
  logic saw;

  initial begin
    rst_n = 1'b0;
    u16.start = 0; u16.block_sel = 0; u16.block_func = 0;
    u16.byte_op = 0; u16.carry_in = 0; u16.shamt = 0;
    u16.src_a = 0; u16.src_b = 0;
    u32.start = 0; u32.block_sel = 0; u32.block_func = 0;
    u32.byte_op = 0; u32.carry_in = 0; u32.shamt = 0;
    u32.src_a = 0; u32.src_b = 0;
    #22;
    chk("rst_busy", 32'(u16.busy), 0);
    chk("rst_done", 32'(u16.done), 0);
    chk("rst_res", 32'(u16.result), 0);
    chk("rst_flags", 32'(fl16()), 0);
    @(negedge clk) rst_n = 1'b1;

    op16(2'd0, 2'd0, 0, 0, 4'd0, 16'hFF81, 16'hFF80, -1, lat, bcnt);
    chk("add_lat", lat, 1);
    chk("add_res", 32'(u16.result), 32'hFF01);
    chk("add_flags", 32'(fl16()), 32'b1010);

    op16(2'd0, 2'd2, 0, 0, 4'd0, 16'h007F, 16'h007F, -1, lat, bcnt);
    chk("sub_res", 32'(u16.result), 32'h0000);
    chk("sub_flags", 32'(fl16()), 32'b1100);

    op16(2'd0, 2'd0, 1, 0, 4'd0, 16'h007F, 16'h007F, -1, lat, bcnt);
    chk("badd_res", 32'(u16.result), 32'h00FE);
    chk("badd_flags", 32'(fl16()), 32'b0011);

    op16(2'd1, 2'd1, 1, 0, 4'd0, 16'h00EF, 16'hFF80, -1, lat, bcnt);
    chk("band_res", 32'(u16.result), 32'hFF80);
    chk("band_flags", 32'(fl16()), 32'b0010);

    op16(2'd3, 2'd0, 0, 1, 4'd0, 16'h1234, 16'h0000, -1, lat, bcnt);
    chk("mov_res", 32'(u16.result), 32'h1234);
    chk("mov_flags", 32'(fl16()), 32'b0010);

    op16(2'd3, 2'd3, 1, 0, 4'd0, 16'h1234, 16'hFFFF, -1, lat, bcnt);
    chk("swpb_res", 32'(u16.result), 32'h3412);
    chk("swpb_flags", 32'(fl16()), 32'b0010);

    op16(2'd2, 2'd3, 0, 0, 4'd4, 16'h0000, 16'h8421, 1, lat, bcnt);
    chk("sll_lat", lat, 5);
    chk("sll_busy", bcnt, 5);
    chk("sll_res", 32'(u16.result), 32'h4210);
    chk("sll_flags", 32'(fl16()), 32'b0000);
    @(posedge clk); #1;
    chk("sll_norestart", 32'({u16.busy, u16.done}), 0);

    op16(2'd2, 2'd3, 1, 0, 4'd1, 16'h0000, 16'h12C1, -1, lat, bcnt);
    chk("bsll_lat", lat, 2);
    chk("bsll_res", 32'(u16.result), 32'h1282);
    chk("bsll_flags", 32'(fl16()), 32'b1010);

    op16(2'd2, 2'd1, 0, 1, 4'd1, 16'h0000, 16'h0001, -1, lat, bcnt);
    chk("rrc_lat", lat, 2);
    chk("rrc_res", 32'(u16.result), 32'h8000);
    chk("rrc_flags", 32'(fl16()), 32'b1010);

    op16(2'd2, 2'd1, 1, 1, 4'd1, 16'h0000, 16'h0001, -1, lat, bcnt);
    chk("brrc_res", 32'(u16.result), 32'h0080);
    chk("brrc_flags", 32'(fl16()), 32'b1010);

    op16(2'd2, 2'd2, 1, 0, 4'd3, 16'h0000, 16'h00AA, -1, lat, bcnt);
    chk("sxt_lat", lat, 1);
    chk("sxt_res", 32'(u16.result), 32'hFFAA);
    chk("sxt_flags", 32'(fl16()), 32'b0010);

    // SRA by 15 aborted by reset three edges after accept.
    @(negedge clk);
    u16.block_sel = 2'd2; u16.block_func = 2'd0;
    u16.byte_op = 0; u16.carry_in = 0;
    u16.shamt = 4'd15; u16.src_b = 16'h8000;
    u16.start = 1'b1;
    @(posedge clk); #1;
    u16.start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(u16.busy), 0);
    chk("abort_done", 32'(u16.done), 0);
    chk("abort_res", 32'(u16.result), 0);
    chk("abort_flags", 32'(fl16()), 0);
    @(negedge clk) rst_n = 1'b1;
    saw = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (u16.done || u16.busy) saw = 1'b1;
    end
    chk("abort_quiet", 32'(saw), 0);

    op16(2'd0, 2'd0, 0, 0, 4'd0, 16'h0001, 16'h0001, -1, lat, bcnt);
    chk("post_lat", lat, 1);
    chk("post_res", 32'(u16.result), 32'h0002);
    chk("post_flags", 32'(fl16()), 32'b0000);

    @(negedge clk);
    u32.block_sel = 2'd0; u32.block_func = 2'd0;
    u32.src_a = 32'h0000_0001; u32.src_b = 32'h0000_FFFF;
    u32.start = 1'b1;
    @(posedge clk); #1;
    u32.start = 1'b0;
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      if (u32.done) begin
        lat = k;
        break;
      end
      @(posedge clk); #1;
    end
    chk("w32_lat", lat, 1);
    chk("w32_res", u32.result, 32'h0001_0000);
    chk("w32_flags",
        32'({u32.carry, u32.zero, u32.neg, u32.ovf}), 32'b0000);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
